// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - mode state type and key index constants for key_conditioner
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } mode_e;

  localparam int KEY_STEP  = 0;
  localparam int KEY_START = 1;
  localparam int KEY_PAUSE = 2;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one-key synchronizer, stability counter and press pulse
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q, sync_q;
  logic          db_q, db_d, db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter clears on any agreement, so it only ever reaches the limit after an unbroken run.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d = '0;
      db_d  = ~db_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= ~key_n_i;
      sync_q   <= meta_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = db_q;
  assign press_o = db_q & ~db_dly_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced step/start/pause keys, run-mode FSM, optional step auto-repeat (KEY_AUTOREPEAT_EN)
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic       step_n,
  output logic       start_p,
  output logic       pause_p,
  output logic       running,
  output logic [2:0] key_db
);

  logic [2:0] press;
  mode_e      state_q, state_d;
  logic       step_n_q, start_p_q, pause_p_q;
  logic       in_run, step_evt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .reset(reset), .key_n_i(key_n[KEY_STEP]),
    .level_o(key_db[KEY_STEP]), .press_o(press[KEY_STEP])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .key_n_i(key_n[KEY_START]),
    .level_o(key_db[KEY_START]), .press_o(press[KEY_START])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .reset(reset), .key_n_i(key_n[KEY_PAUSE]),
    .level_o(key_db[KEY_PAUSE]), .press_o(press[KEY_PAUSE])
  );

  assign in_run = (state_q == RUN);

  // A simultaneous start blocks the pause transition, so RUN is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press[KEY_START]) state_d = RUN;
      RUN:     if (press[KEY_PAUSE] && !press[KEY_START]) state_d = PAUSED;
      PAUSED:  if (press[KEY_START]) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_arm_q, rpt_arm_d;
  logic          rpt_first_q, rpt_first_d;
  logic          rpt_fire;

  // Timer counts cycles since the last emitted step; first gap is the delay, later gaps the period.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_arm_d   = rpt_arm_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (press[KEY_STEP] && in_run) begin
      rpt_arm_d   = 1'b1;
      rpt_first_d = 1'b1;
      rpt_cnt_d   = RW'(1);
    end else if (rpt_arm_q && key_db[KEY_STEP] && in_run) begin
      if (rpt_cnt_q == (rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
        rpt_cnt_d   = RW'(1);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end else begin
      rpt_arm_d   = 1'b0;
      rpt_first_d = 1'b0;
      rpt_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_arm_q   <= 1'b0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_arm_q   <= rpt_arm_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign step_evt = (press[KEY_STEP] && in_run) || rpt_fire;
`else
  assign step_evt = press[KEY_STEP] && in_run;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      step_n_q  <= 1'b1;
      start_p_q <= 1'b0;
      pause_p_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_n_q  <= ~step_evt;
      start_p_q <= press[KEY_START];
      pause_p_q <= press[KEY_PAUSE];
    end
  end

  assign step_n  = step_n_q;
  assign start_p = start_p_q;
  assign pause_p = pause_p_q;
  assign running = in_run;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed and randomized bench for key_conditioner against a window-based model
module tb_key_conditioner;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       step_n, start_p, pause_p, running;
  logic [2:0] key_db;

  key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .step_n(step_n),
    .start_p(start_p), .pause_p(pause_p), .running(running), .key_db(key_db)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: sync is a 2-cycle delay; a key's level flips once the last D synced samples all disagree with it.
  bit [2:0] m_s1, m_s2, m_db, m_db_prev;
  bit       hist[3][$];
  int       m_mode;
  bit       m_armed;
  int       m_last, m_gap;
  bit       e_step_n, e_start, e_pause;

  int step_q[$];
  int start_q[$];
  int pause_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit [2:0] raw, press;
    bit fire, all_diff;
    @(posedge clk);
    #1;
    cyc++;
    raw = ~key_n;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0;
      m_mode = M_IDLE; m_armed = 0;
      e_step_n = 1; e_start = 0; e_pause = 0;
      for (int k = 0; k < 3; k++) begin
        hist[k].delete();
        repeat (D) hist[k].push_back(1'b0);
      end
    end else begin
      press   = m_db & ~m_db_prev;
      e_start = press[1];
      e_pause = press[2];
      fire    = press[0] && (m_mode == M_RUN);
`ifdef KEY_AUTOREPEAT_EN
      if (fire) begin
        m_armed = 1; m_last = cyc; m_gap = RD;
      end else if (m_armed && m_db[0] && m_mode == M_RUN) begin
        if (cyc - m_last == m_gap) begin
          fire = 1; m_last = cyc; m_gap = RP;
        end
      end else begin
        m_armed = 0;
      end
`endif
      e_step_n = ~fire;
      if (press[1]) begin
        if (m_mode != M_RUN) m_mode = M_RUN;
      end else if (press[2] && m_mode == M_RUN) begin
        m_mode = M_PAUSED;
      end
      m_db_prev = m_db;
      for (int k = 0; k < 3; k++) begin
        all_diff = 1;
        for (int i = 0; i < hist[k].size(); i++)
          if (hist[k][i] == m_db[k]) all_diff = 0;
        if (all_diff) m_db[k] = ~m_db[k];
      end
      m_s2 = m_s1;
      m_s1 = raw;
      for (int k = 0; k < 3; k++) begin
        hist[k].push_back(m_s2[k]);
        void'(hist[k].pop_front());
      end
    end
    chk("step_n", 32'(step_n), 32'(e_step_n));
    chk("start_p", 32'(start_p), 32'(e_start));
    chk("pause_p", 32'(pause_p), 32'(e_pause));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("key_db", 32'(key_db), 32'(m_db));
    if (step_n === 1'b0) step_q.push_back(cyc);
    if (start_p === 1'b1) start_q.push_back(cyc);
    if (pause_p === 1'b1) pause_q.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_q();
    step_q.delete(); start_q.delete(); pause_q.delete();
  endtask

  function automatic int first_off(input int q[$], input int base);
    return (q.size() > 0) ? q[0] - base : -1;
  endfunction

  initial begin
    int p, r;
    int rem[3];
    int exp_off[$];

    key_n = 3'b111;
    reset = 1'b1;
    run(3);
    chk("rst_step_n", 32'(step_n), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_key_db", 32'(key_db), 32'd0);
    reset = 1'b0;

    // step in IDLE is discarded
    clear_q();
    key_n[0] = 1'b0; run(20);
    key_n[0] = 1'b1; run(14);
    chk("idle_step_none", 32'(step_q.size()), 32'd0);

    // start press: pulse 11 cycles after press
    clear_q();
    p = cyc;
    key_n[1] = 1'b0; run(20);
    chk("start_count", 32'(start_q.size()), 32'd1);
    chk("start_latency", 32'(first_off(start_q, p)), 32'd11);
    chk("start_running", 32'(running), 32'd1);
    key_n[1] = 1'b1; run(14);
    chk("start_release_nopulse", 32'(start_q.size()), 32'd1);

    // bounced step press
    clear_q();
    for (int b = 0; b < 4; b++) begin
      key_n[0] = 1'b0; run(5);
      key_n[0] = 1'b1; run(2);
    end
    p = cyc;
    key_n[0] = 1'b0; run(20);
    key_n[0] = 1'b1; run(14);
    chk("bounce_step_count", 32'(step_q.size()), 32'd1);
    chk("bounce_step_latency", 32'(first_off(step_q, p)), 32'd11);

    // simultaneous start+pause in RUN, then pause, then start
    clear_q();
    key_n[2:1] = 2'b00; run(20);
    key_n[2:1] = 2'b11; run(14);
    chk("both_start", 32'(start_q.size()), 32'd1);
    chk("both_pause", 32'(pause_q.size()), 32'd1);
    chk("both_same_cycle", 32'(first_off(start_q, 0)), 32'(first_off(pause_q, 0)));
    chk("both_stays_run", 32'(running), 32'd1);
    key_n[2] = 1'b0; run(20);
    key_n[2] = 1'b1; run(14);
    chk("pause_running", 32'(running), 32'd0);
    key_n[1] = 1'b0; run(20);
    key_n[1] = 1'b1; run(14);
    chk("resume_running", 32'(running), 32'd1);

    // long step hold in RUN
    clear_q();
    p = cyc;
    key_n[0] = 1'b0; run(100);
    key_n[0] = 1'b1; run(30);
`ifdef KEY_AUTOREPEAT_EN
    exp_off = '{11, 11 + RD, 11 + RD + RP, 11 + RD + 2 * RP, 11 + RD + 3 * RP};
`else
    exp_off = '{11};
`endif
    chk("hold_step_count", 32'(step_q.size()), 32'(exp_off.size()));
    for (int i = 0; i < exp_off.size(); i++)
      chk("hold_step_time", 32'((i < step_q.size()) ? step_q[i] - p : -1), 32'(exp_off[i]));

    // reset 4 cycles into a start press
    clear_q();
    key_n[1] = 1'b0; run(4);
    reset = 1'b1; tick();
    chk("midrst_step_n", 32'(step_n), 32'd1);
    chk("midrst_start_p", 32'(start_p), 32'd0);
    chk("midrst_pause_p", 32'(pause_p), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_key_db", 32'(key_db), 32'd0);
    reset = 1'b0;
    r = cyc;
    run(20);
    chk("midrst_start_count", 32'(start_q.size()), 32'd1);
    chk("midrst_start_latency", 32'(first_off(start_q, r)), 32'd11);
    key_n[1] = 1'b1; run(14);

    // randomized key activity with occasional resets
    for (int k = 0; k < 3; k++) rem[k] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          rem[k] = $urandom_range(1, 14);
        end
        rem[k]--;
      end
      reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0;
    key_n = 3'b111;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable clk cycles before a debounced key changes (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles the step key is held before the first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, SHALL set the cycles between subsequent auto-repeats.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 key_n  input  3  SHALL carry the raw asynchronous active-low pushbuttons: [0] step, [1] start, [2] pause.
REQ-007 step_n  output  1  SHALL be low for exactly one cycle per accepted step event (feeds the downstream state machine's advance input).
REQ-008 start_p  output  1  SHALL be a one-cycle high pulse per accepted start press.
REQ-009 pause_p  output  1  SHALL be a one-cycle high pulse per accepted pause press.
REQ-010 running  output  1  SHALL be high in RUN, low in IDLE and PAUSED.
REQ-011 key_db  output  3  SHALL carry the debounced key levels, active-high (1 = pressed).

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per key, a counter SHALL reset to 0 whenever the synchronized level equals key_db and SHALL increment otherwise; key_db SHALL toggle when the counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL then clear.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-015 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no key_db change and no pulse.
REQ-016 Press events SHALL come from the rising edge of key_db; the pulse SHALL appear the cycle after key_db rises. Releases SHALL produce no pulse.
REQ-017 Total latency from stable raw press to pulse SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-018 Mode FSM states IDLE, RUN, PAUSED: IDLE--start-->RUN; RUN--pause-->PAUSED; PAUSED--start-->RUN; pause in IDLE, start in RUN, pause in PAUSED SHALL be ignored.
REQ-019 Start and pause press events in the same cycle: start_p and pause_p SHALL both pulse; FSM SHALL take the start transition (start wins).
REQ-020 Step events SHALL be emitted on step_n only while running is high; step presses in IDLE/PAUSED SHALL be discarded, not queued.
REQ-021 step_n, start_p, pause_p SHALL be registered outputs.

Reset
REQ-022 On reset: synchronizers, counters cleared; key_db = 3'b000; step_n = 1; start_p = pause_p = 0; FSM = IDLE; running = 0; repeat timer cleared.
REQ-023 A key held through reset deassertion SHALL register as a new press after the full debounce latency.
REQ-024 Reset mid-debounce SHALL discard the partial count.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: while key_db[0] is held in RUN, an extra step event SHALL fire REPEAT_DELAY cycles after the initial one, then every REPEAT_PERIOD cycles until release or leaving RUN.
REQ-026 KEY_AUTOREPEAT_EN undefined: exactly one step event per press; repeat timer and parameters unused, no repeat logic synthesized.

Structure
REQ-027 Package key_cond_pkg SHALL hold the mode state enum (IDLE, RUN, PAUSED) and key index constants KEY_STEP=0, KEY_START=1, KEY_PAUSE=2.
REQ-028 Sub-module key_debounce (synchronizer + counter + rising-edge pulse, one key) SHALL be instantiated three times; FSM and auto-repeat live in key_conditioner.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=16 for sim)
REQ-029 Reset, press key_n[1] low steady 20 cycles -> start_p single pulse at cycle 11 after press, running=1 thereafter.
REQ-030 Bounce key_n[0] low 5 cycles/high 2, repeat 4x, then hold low -> exactly one step_n low pulse, only after the steady hold.
REQ-031 In IDLE press step -> step_n stays 1; after start, press step -> one step_n low pulse.
REQ-032 In RUN, press start and pause in the same cycle -> start_p=pause_p=1 same cycle, state stays RUN; then pause alone -> running=0; start -> running=1.
REQ-033 Assert reset for 1 cycle 4 cycles into a press -> no pulse until 11 cycles after reset released; all outputs at reset values during reset.
REQ-034 With KEY_AUTOREPEAT_EN, hold step 100 cycles in RUN -> pulses at t0, t0+40, t0+56, t0+72, t0+88; without macro -> only t0.
